// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI memory responder (READ 0x03 / WRITE 0x02) backed by a 2**ADDR_W byte RAM.
// Optional macro IDLI_SQI_MEM_RDMR_EN enables RDMR (0x01), which returns mode byte 0x40 repeatedly.
module idli_sqi_mem_m #(
    parameter int ADDR_W = 8
) (
    input  logic       i_sqi_gck,
    input  logic       i_sqi_rst_n,
    input  logic       i_sqi_sck,
    input  logic       i_sqi_cs,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio,
    output logic       o_sqi_sio_oe
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, INSTR, ADDR, DUMMY, RDATA, WDATA, DISCARD, RDMR} state_t;

    state_t            r_state;
    logic [3:0]        r_hi;
    logic [15:0]       r_addr;
    logic [1:0]        r_cnt;
    logic              r_rd;
    logic              r_nib;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] w_idx;
    logic [ADDR_W-1:0] w_nxt;
    logic [7:0]        w_op;

    // Only the low ADDR_W address bits select a byte; the increment wraps naturally in that range.
    assign w_idx = r_addr[ADDR_W-1:0];
    assign w_nxt = w_idx + 1'b1;
    assign w_op  = {r_hi, i_sqi_sio};

    // Protocol FSM, RAM writes and registered read data; cs=1 wins over any beat.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            r_state      <= IDLE;
            r_hi         <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_rd         <= 1'b0;
            r_nib        <= 1'b0;
            o_sqi_sio    <= '0;
            o_sqi_sio_oe <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_sqi_cs) begin
            r_state      <= IDLE;
            o_sqi_sio_oe <= 1'b0;
        end else if (i_sqi_sck) begin
            case (r_state)
                IDLE: begin
                    r_hi    <= i_sqi_sio;
                    r_state <= INSTR;
                end
                INSTR: begin
                    r_cnt <= '0;
                    r_rd  <= (w_op == 8'h03);
                    if (w_op == 8'h03 || w_op == 8'h02) r_state <= ADDR;
`ifdef IDLI_SQI_MEM_RDMR_EN
                    else if (w_op == 8'h01) begin
                        r_state      <= RDMR;
                        o_sqi_sio    <= 4'h4;
                        o_sqi_sio_oe <= 1'b1;
                    end
`endif
                    else r_state <= DISCARD;
                end
                ADDR: begin
                    r_addr <= {r_addr[11:0], i_sqi_sio};
                    r_cnt  <= r_cnt + 1'b1;
                    r_nib  <= 1'b0;
                    if (r_cnt == 2'd3) r_state <= r_rd ? DUMMY : WDATA;
                end
                DUMMY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == 2'd1) begin
                        o_sqi_sio    <= r_mem[w_idx][7:4];
                        o_sqi_sio_oe <= 1'b1;
                        r_nib        <= 1'b1;
                        r_state      <= RDATA;
                    end
                end
                RDATA: begin
                    r_nib <= !r_nib;
                    if (r_nib) o_sqi_sio <= r_mem[w_idx][3:0];
                    else begin
                        r_addr    <= r_addr + 16'd1;
                        o_sqi_sio <= r_mem[w_nxt][7:4];
                    end
                end
                WDATA: begin
                    r_nib <= !r_nib;
                    if (!r_nib) r_hi <= i_sqi_sio;
                    else begin
                        r_mem[w_idx] <= w_op;
                        r_addr       <= r_addr + 16'd1;
                    end
                end
`ifdef IDLI_SQI_MEM_RDMR_EN
                RDMR: o_sqi_sio <= o_sqi_sio ^ 4'h4;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// tb_idli_sqi_mem_m: directed self-checking bench for the SQI memory responder.
module tb_idli_sqi_mem_m;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic [3:0] sio = '0;
    logic [3:0] o_sio;
    logic       oe;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    idli_sqi_mem_m #(.ADDR_W(8)) dut (
        .i_sqi_gck(clk),
        .i_sqi_rst_n(rst_n),
        .i_sqi_sck(sck),
        .i_sqi_cs(cs),
        .i_sqi_sio(sio),
        .o_sqi_sio(o_sio),
        .o_sqi_sio_oe(oe)
    );

    task automatic beat(input logic [3:0] n);
        @(negedge clk); cs = 1'b0; sck = 1'b1; sio = n;
        @(posedge clk); #1;
    endtask

    task automatic rbeat(output logic [3:0] n, output logic e);
        @(negedge clk); cs = 1'b0; sck = 1'b1; sio = 4'h0; n = o_sio; e = oe;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        beat(b[7:4]);
        beat(b[3:0]);
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk); cs = 1'b0; sck = 1'b0;
        end
    endtask

    task automatic deselect(input logic s);
        @(negedge clk); cs = 1'b1; sck = s; sio = 4'hF;
        @(posedge clk); #1;
        @(negedge clk); sck = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] op, input logic [15:0] a);
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic start_read(input logic [15:0] a);
        cmd(8'h03, a);
        beat(4'h0);
        beat(4'h0);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic e);
        logic [3:0] h, l;
        logic e1, e2;
        rbeat(h, e1);
        rbeat(l, e2);
        b = {h, l};
        e = e1 & e2;
    endtask

    task automatic test_reset;
        logic [7:0] b;
        logic e;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_sio !== 4'h0 || oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: sio=%h oe=%b, expected sio=0 oe=0", o_sio, oe);
        end
        @(negedge clk); rst_n = 1'b1;
        start_read(16'h0000);
        read_byte(b, e);
        checks++;
        if (b !== 8'h00 || e !== 1'b1) begin
            errors++;
            $display("FAIL reset_ram: got %h oe=%b, expected 00 oe=1", b, e);
        end
        deselect(1'b0);
    endtask

    task automatic test_write_read;
        logic [7:0] b;
        logic e;
        cmd(8'h02, 16'h0010);
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL write_oe: oe=%b, expected 0", oe);
        end
        send_byte(8'hA5);
        send_byte(8'h3C);
        deselect(1'b0);
        cmd(8'h03, 16'h0010);
        beat(4'h0);
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL dummy1_oe: oe=%b, expected 0", oe);
        end
        beat(4'h0);
        checks++;
        if (oe !== 1'b1 || o_sio !== 4'hA) begin
            errors++;
            $display("FAIL dummy2_load: sio=%h oe=%b, expected sio=a oe=1", o_sio, oe);
        end
        read_byte(b, e);
        checks++;
        if (b !== 8'hA5 || e !== 1'b1) begin
            errors++;
            $display("FAIL read_byte0: got %h oe=%b, expected a5 oe=1", b, e);
        end
        read_byte(b, e);
        checks++;
        if (b !== 8'h3C || e !== 1'b1) begin
            errors++;
            $display("FAIL read_byte1: got %h oe=%b, expected 3c oe=1", b, e);
        end
        deselect(1'b0);
        checks++;
        if (oe !== 1'b0) begin
            errors++;
            $display("FAIL cs_release_oe: oe=%b, expected 0", oe);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] b;
        logic e;
        cmd(8'h02, 16'h12FF);
        send_byte(8'h11);
        send_byte(8'h22);
        deselect(1'b0);
        start_read(16'h00FF);
        read_byte(b, e);
        checks++;
        if (b !== 8'h11) begin
            errors++;
            $display("FAIL wrap_ff: got %h, expected 11", b);
        end
        read_byte(b, e);
        checks++;
        if (b !== 8'h22) begin
            errors++;
            $display("FAIL wrap_stream_00: got %h, expected 22", b);
        end
        deselect(1'b0);
        start_read(16'h0000);
        read_byte(b, e);
        checks++;
        if (b !== 8'h22) begin
            errors++;
            $display("FAIL wrap_00: got %h, expected 22", b);
        end
        deselect(1'b0);
    endtask

    task automatic test_truncation;
        logic [7:0] b;
        logic e;
        cmd(8'h02, 16'h0020);
        send_byte(8'h55);
        send_byte(8'h66);
        deselect(1'b0);
        cmd(8'h02, 16'h0020);
        beat(4'h7);
        beat(4'h8);
        beat(4'h9);
        deselect(1'b1);
        start_read(16'h0020);
        read_byte(b, e);
        checks++;
        if (b !== 8'h78) begin
            errors++;
            $display("FAIL trunc_20: got %h, expected 78", b);
        end
        read_byte(b, e);
        checks++;
        if (b !== 8'h66) begin
            errors++;
            $display("FAIL trunc_21: got %h, expected 66", b);
        end
        deselect(1'b0);
    endtask

    task automatic test_stall;
        logic [3:0] n;
        logic e;
        logic [3:0] exp [4];
        exp[0] = 4'hA; exp[1] = 4'h5; exp[2] = 4'h3; exp[3] = 4'hC;
        start_read(16'h0010);
        for (int i = 0; i < 4; i++) begin
            stall(5);
            rbeat(n, e);
            checks++;
            if (n !== exp[i] || e !== 1'b1) begin
                errors++;
                $display("FAIL stall_nib%0d: got %h oe=%b, expected %h oe=1", i, n, e, exp[i]);
            end
        end
        deselect(1'b0);
    endtask

    task automatic test_unknown;
        logic [3:0] n;
        logic e;
        int bad = 0;
        send_byte(8'hFF);
        for (int i = 0; i < 10; i++) begin
            rbeat(n, e);
            if (e !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL unknown_oe: oe high on %0d beats, expected 0", bad);
        end
        deselect(1'b0);
    endtask

    task automatic test_rdmr;
        logic [3:0] n;
        logic e;
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) begin
            rbeat(n, e);
            checks++;
`ifdef IDLI_SQI_MEM_RDMR_EN
            if (n !== ((i % 2 == 0) ? 4'h4 : 4'h0) || e !== 1'b1) begin
                errors++;
                $display("FAIL rdmr_nib%0d: got %h oe=%b, expected %h oe=1", i, n, e, (i % 2 == 0) ? 4'h4 : 4'h0);
            end
`else
            if (e !== 1'b0) begin
                errors++;
                $display("FAIL rdmr_disabled%0d: oe=%b, expected 0", i, e);
            end
`endif
        end
        deselect(1'b0);
    endtask

    task automatic test_reset_mid;
        logic [3:0] n;
        logic [7:0] b;
        logic e;
        cmd(8'h02, 16'h0030);
        send_byte(8'hC3);
        deselect(1'b0);
        start_read(16'h0030);
        rbeat(n, e);
        checks++;
        if (n !== 4'hC || e !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_read: got %h oe=%b, expected c oe=1", n, e);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_sio !== 4'h0 || oe !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sio=%h oe=%b, expected sio=0 oe=0", o_sio, oe);
        end
        @(negedge clk); cs = 1'b1; sck = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        start_read(16'h0030);
        read_byte(b, e);
        checks++;
        if (b !== 8'h00) begin
            errors++;
            $display("FAIL reset_clear_30: got %h, expected 00", b);
        end
        deselect(1'b0);
        start_read(16'h0010);
        read_byte(b, e);
        checks++;
        if (b !== 8'h00) begin
            errors++;
            $display("FAIL reset_clear_10: got %h, expected 00", b);
        end
        deselect(1'b0);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_wrap;
        test_truncation;
        test_stall;
        test_unknown;
        test_rdmr;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
